// File: rtl/instruction_fetch_unit.sv
// Fetch unit: word-aligned PC into instruction memory, {pc,inst} buffered in a DEPTH-entry FIFO to decode.
// Latency 1 cycle address-to-head; read_en drops only when FIFO full or redirecting, never on inst_ready.
module instruction_fetch_unit #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned DEPTH    = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] address,
  output logic              read_en,
  output logic              ce,
  input  logic [DATA_W-1:0] data,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] insn;
  } fetch_entry_t;

  fetch_entry_t             fifo_mem [DEPTH];
  logic [ADDR_W-1:0]        fetch_pc;
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic [CNT_W-1:0]         count;
  logic                     push;
  logic                     pop;
  fetch_entry_t             head;

  // Issue depends only on registered occupancy and the redirect, keeping the memory path short.
  assign read_en    = (count < CNT_W'(DEPTH)) && !branch_taken && !reset;
  assign ce         = read_en;
  assign address    = fetch_pc;
  assign inst_valid = (count != '0);

  assign push = read_en;
  assign pop  = inst_valid && inst_ready && !branch_taken;

  assign head    = fifo_mem[rd_ptr];
  assign inst    = inst_valid ? head.insn : '0;
  assign inst_pc = inst_valid ? head.pc   : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (branch_taken) begin
      fetch_pc <= {branch_target[ADDR_W-1:2], 2'b00};
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + PTR_W'(1);
        fetch_pc <= fetch_pc + ADDR_W'(4);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: outputs are masked by inst_valid while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{pc: fetch_pc, insn: data};
    end
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Initiator side of the instruction-memory read interface: generates word-aligned fetch addresses, drives `address`/`read_en`/`ce` into `MemoriaInstrucciones`, and captures the returned `data` into a small FIFO. The FIFO feeds the decode stage through a valid/ready handshake. A taken branch redirects the fetch PC and flushes the buffered instructions.

## Interface
- `ADDR_W`, 32, width of fetch address and PC
- `DATA_W`, 32, instruction width
- `RESET_PC`, 32'h0000_0000, first fetch address after reset (word-aligned)
- `DEPTH`, 2, instruction FIFO entries (power of two, ≥2)

- `clk`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `address`  out  ADDR_W  fetch address to instruction memory (= fetch_pc)
- `read_en`  out  1  memory read request
- `ce`  out  1  memory chip enable; always equal to `read_en`
- `data`  in  DATA_W  instruction word from memory; combinational, valid in the same cycle as `address`
- `branch_taken`  in  1  redirect request from execute
- `branch_target`  in  ADDR_W  redirect address
- `inst_valid`  out  1  FIFO head holds a valid instruction
- `inst_ready`  in  1  decode accepts the head this cycle
- `inst`  out  DATA_W  instruction at the FIFO head
- `inst_pc`  out  ADDR_W  address the head instruction was fetched from

## Operation
- State: `fetch_pc`; a FIFO of {pc, instruction} with read/write pointers and an occupancy count (0..DEPTH).
- Issue: `read_en = ce = (count < DEPTH) && !branch_taken && !reset`. This is a combinational decode of registered count plus `branch_taken` only. It never depends on `inst_ready`.
- Push: on an edge where `read_en` is 1, write {fetch_pc, data} at the write pointer. `fetch_pc` advances by 4 and wraps modulo 2^ADDR_W, so 32'hFFFF_FFFC goes to 0.
- Pop: on an edge where `inst_valid && inst_ready`, advance the read pointer.
- Push and pop on the same edge: count is unchanged.
- Pop when full: no push that cycle, because `read_en` was 0. The next cycle issues again.
- Redirect has priority over push and pop. On an edge with `branch_taken` = 1:
  - the FIFO is flushed (count = 0, pointers reset);
  - `fetch_pc` is set to `{branch_target[ADDR_W-1:2], 2'b00}`; the low two bits are silently forced to zero;
  - any pop handshake that cycle is dropped, so decode must ignore that head;
  - nothing is pushed.
- `branch_taken` held for several cycles: each cycle re-flushes and reloads `fetch_pc`. The last target wins.
- `inst_valid = (count != 0)`.
- `inst` and `inst_pc` show the FIFO head when valid and are 0 when empty.
- Reset (async assert, including mid-operation): `fetch_pc = RESET_PC` and the FIFO is empty. All outputs go to 0 immediately: `address` = RESET_PC, `read_en` = 0, `ce` = 0, `inst_valid` = 0, `inst` = 0, `inst_pc` = 0.
- Reset release: the release is synchronized by the deasserting edge. The first cycle after release drives `address` = RESET_PC with `read_en` = 1.

## Timing
- Fetch latency: an instruction at `address` in cycle N appears as the FIFO head (`inst_valid` = 1) in cycle N+1.
- Steady-state throughput: 1 instruction per cycle while `inst_ready` = 1 every cycle.
- Redirect latency: `branch_taken` sampled at the edge ending cycle N. In cycle N+1, `address` = target and `inst_valid` = 0. In cycle N+2, `inst` = mem[target] and `inst_pc` = target.
- Backpressure: with `inst_ready` = 0, the FIFO fills in DEPTH cycles and then `read_en` drops. `address` holds at the next unfetched PC.
- Flow control is lossless: no instruction is skipped or duplicated except through a flush.

## Test plan
- Reset and stream: reset high for 3 cycles, then release with `inst_ready` = 1 and mem[i] = i·4 + 32'hA000_0000 → `read_en` = 0 during reset. Cycle 1 after release: `inst_pc` = 0, `inst` = 32'hA000_0000. Then `inst_pc` takes 4, 8, 12 on consecutive cycles.
- Backpressure: hold `inst_ready` = 0 for 5 cycles → `read_en` falls after 2 fetches and `address` holds at 8. Release `inst_ready` → heads 0, 4, 8 appear in order with no gaps or duplicates.
- Branch redirect: while streaming at pc 12, assert `branch_taken` for one cycle with target 32'h0000_0215 → `address` = 32'h214 next cycle. The following cycle `inst_pc` = 32'h214. Old entries (16, 20) never appear.
- Branch while full plus same-cycle pop: FIFO full, `inst_ready` = 1 and `branch_taken` = 1 on the same edge → count goes to 0 and the popped head is not counted as accepted by the bench model. Next head is the target.
- Wrap-around: redirect to 32'hFFFF_FFF8 → `inst_pc` sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Async reset mid-stream: assert `reset` between clock edges with FIFO count 1 → `inst_valid`, `read_en`, `ce` go to 0 before the next edge. After release, fetch restarts at RESET_PC.
